// File: rtl/decode_execute_latch.sv
// decode_execute_latch: ID/EX pipeline register.
// Latches the decoded instruction and its register-file operands. Produces
// forwarded execute operands from EX/MEM and MEM/WB, and inserts a single
// bubble on a load-use hazard. The register file writes on the falling edge,
// so a same-cycle WB write is already present in id_rdat1/2 and is not
// forwarded here.
module decode_execute_latch #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [DW-1:0] id_rdat1,
    input  logic [DW-1:0] id_rdat2,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_wsel,
    input  logic          id_wen,
    input  logic          id_memread,
    input  logic [CW-1:0] id_ctrl,
    input  logic [RW-1:0] exmem_wsel,
    input  logic          exmem_wen,
    input  logic          exmem_memread,
    input  logic [DW-1:0] exmem_result,
    input  logic [RW-1:0] memwb_wsel,
    input  logic          memwb_wen,
    input  logic [DW-1:0] memwb_wdat,
    input  logic          flush,
    input  logic          ex_hold,
    output logic          stall_id,
    output logic          ex_valid,
    output logic          ex_wen,
    output logic          ex_memread,
    output logic [RW-1:0] ex_wsel,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [DW-1:0] ex_imm,
    output logic [CW-1:0] ex_ctrl,
    output logic [DW-1:0] ex_opA,
    output logic [DW-1:0] ex_opB
);

    // Operands as captured from the register file (or refreshed during a hold).
    logic [DW-1:0] rdat1_q;
    logic [DW-1:0] rdat2_q;
    logic          lu;

    // Select the newest in-flight value for a source register. $0 is never
    // forwarded, and a load in MEM has no data yet so it is skipped.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [DW-1:0] stored,
        input logic [RW-1:0] mem_wsel,
        input logic          mem_wen,
        input logic          mem_rd,
        input logic [DW-1:0] mem_res,
        input logic [RW-1:0] wb_wsel,
        input logic          wb_wen,
        input logic [DW-1:0] wb_dat
    );
        logic [DW-1:0] r;
        r = stored;
        if (src != '0) begin
            if (mem_wen && !mem_rd && (mem_wsel == src)) begin
                r = mem_res;
            end else if (wb_wen && (wb_wsel == src)) begin
                r = wb_dat;
            end
        end
        return r;
    endfunction

    // Load in EX whose destination is read by the instruction in decode.
    always_comb begin
        lu = ex_valid && ex_memread && (ex_wsel != '0) && id_valid &&
             ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    end

    // Decode must hold on a hazard bubble or whenever EX is frozen.
    always_comb begin
        stall_id = lu || ex_hold;
    end

    // Forwarded execute operands.
    always_comb begin
        ex_opA = fwd_sel(ex_rs, rdat1_q, exmem_wsel, exmem_wen, exmem_memread,
                         exmem_result, memwb_wsel, memwb_wen, memwb_wdat);
        ex_opB = fwd_sel(ex_rt, rdat2_q, exmem_wsel, exmem_wen, exmem_memread,
                         exmem_result, memwb_wsel, memwb_wen, memwb_wdat);
    end

    // Pipeline register update: flush > hold > load-use bubble > capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid   <= 1'b0;
            ex_wen     <= 1'b0;
            ex_memread <= 1'b0;
            ex_wsel    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_imm     <= '0;
            ex_ctrl    <= '0;
            rdat1_q    <= '0;
            rdat2_q    <= '0;
        end else if (flush || (lu && !ex_hold)) begin
            ex_valid   <= 1'b0;
            ex_wen     <= 1'b0;
            ex_memread <= 1'b0;
            ex_wsel    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_imm     <= '0;
            ex_ctrl    <= '0;
            rdat1_q    <= '0;
            rdat2_q    <= '0;
        end else if (ex_hold) begin
            // Keep a forwarded value alive after its producer retires.
            rdat1_q <= ex_opA;
            rdat2_q <= ex_opB;
        end else begin
            ex_valid   <= id_valid;
            ex_wen     <= id_wen && id_valid;
            ex_memread <= id_memread && id_valid;
            ex_wsel    <= id_wsel;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_imm     <= id_imm;
            ex_ctrl    <= id_ctrl;
            rdat1_q    <= id_rdat1;
            rdat2_q    <= id_rdat2;
        end
    end

endmodule

// File: tb/tb_decode_execute_latch.sv
// Bench for decode_execute_latch: directed scenarios followed by random
// traffic. A reference model predicts what EX should present each cycle and
// queues it; an independent monitor compares the DUT just before each edge.
module tb_decode_execute_latch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid, id_wen, id_memread;
    logic [4:0]  id_rs, id_rt, id_wsel;
    logic [31:0] id_rdat1, id_rdat2, id_imm;
    logic [15:0] id_ctrl;
    logic [4:0]  exmem_wsel, memwb_wsel;
    logic        exmem_wen, exmem_memread, memwb_wen;
    logic [31:0] exmem_result, memwb_wdat;
    logic        flush, ex_hold;
    logic        stall_id, ex_valid, ex_wen, ex_memread;
    logic [4:0]  ex_wsel, ex_rs, ex_rt;
    logic [31:0] ex_imm, ex_opA, ex_opB;
    logic [15:0] ex_ctrl;

    decode_execute_latch #(.DW(32), .RW(5), .CW(16)) dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
        .id_wsel(id_wsel), .id_wen(id_wen), .id_memread(id_memread),
        .id_ctrl(id_ctrl),
        .exmem_wsel(exmem_wsel), .exmem_wen(exmem_wen),
        .exmem_memread(exmem_memread), .exmem_result(exmem_result),
        .memwb_wsel(memwb_wsel), .memwb_wen(memwb_wen), .memwb_wdat(memwb_wdat),
        .flush(flush), .ex_hold(ex_hold),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_wen(ex_wen),
        .ex_memread(ex_memread), .ex_wsel(ex_wsel), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_opA(ex_opA), .ex_opB(ex_opB)
    );

    always #5 CLK = ~CLK;

    // Contents of the EX stage as the reference sees it.
    typedef struct packed {
        logic        valid, wen, memread;
        logic [4:0]  wsel, rs, rt;
        logic [31:0] imm, a, b;
        logic [15:0] ctrl;
    } stage_t;

    typedef struct packed {
        logic        in_rst, valid, wen, memread, stall;
        logic [4:0]  wsel, rs, rt;
        logic [31:0] imm, opa, opb;
        logic [15:0] ctrl;
    } exp_t;

    stage_t m;
    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;

    // Value EX sees for a source: newest producer wins, $0 is hardwired.
    function automatic logic [31:0] ref_operand(input logic [4:0] src, input logic [31:0] stored);
        if (src == 0) return stored;
        if (exmem_wen && !exmem_memread && exmem_wsel == src) return exmem_result;
        if (memwb_wen && memwb_wsel == src) return memwb_wdat;
        return stored;
    endfunction

    // Predict this cycle's EX view, queue it, then advance the model one edge.
    task automatic step();
        exp_t        e;
        logic [31:0] oa, ob;
        logic        hazard;
        if (RST) m = '0;
        oa = ref_operand(m.rs, m.a);
        ob = ref_operand(m.rt, m.b);
        hazard = m.valid && m.memread && m.wsel != 0 && id_valid &&
                 (m.wsel == id_rs || m.wsel == id_rt);
        e.in_rst = RST; e.valid = m.valid; e.wen = m.wen; e.memread = m.memread;
        e.stall = hazard || ex_hold;
        e.wsel = m.wsel; e.rs = m.rs; e.rt = m.rt; e.imm = m.imm; e.ctrl = m.ctrl;
        e.opa = oa; e.opb = ob;
        sb.push_back(e);
        if (!RST) begin
            if (flush) m = '0;
            else if (ex_hold) begin m.a = oa; m.b = ob; end
            else if (hazard) m = '0;
            else begin
                m.valid = id_valid; m.wen = id_wen && id_valid;
                m.memread = id_memread && id_valid;
                m.wsel = id_wsel; m.rs = id_rs; m.rt = id_rt;
                m.imm = id_imm; m.ctrl = id_ctrl; m.a = id_rdat1; m.b = id_rdat2;
            end
        end
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    task automatic quiet();
        RST = 0; id_valid = 0; id_wen = 0; id_memread = 0;
        id_rs = 0; id_rt = 0; id_wsel = 0; id_rdat1 = 0; id_rdat2 = 0;
        id_imm = 0; id_ctrl = 0;
        exmem_wsel = 0; exmem_wen = 0; exmem_memread = 0; exmem_result = 0;
        memwb_wsel = 0; memwb_wen = 0; memwb_wdat = 0;
        flush = 0; ex_hold = 0;
    endtask

    task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wd,
                          input logic ld, input logic [31:0] d1, input logic [31:0] d2);
        id_valid = 1; id_wen = 1; id_memread = ld; id_rs = rs; id_rt = rt; id_wsel = wd;
        id_rdat1 = d1; id_rdat2 = d2; id_imm = $urandom; id_ctrl = 16'($urandom);
    endtask

    task automatic randomize_inputs(input bit allow_hold);
        id_valid = ($urandom_range(0, 9) < 8); id_wen = 1'($urandom);
        id_memread = ($urandom_range(0, 2) == 0);
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_wsel = 5'($urandom_range(0, 7));
        id_rdat1 = $urandom; id_rdat2 = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
        exmem_wsel = 5'($urandom_range(0, 7)); exmem_wen = 1'($urandom);
        exmem_memread = ($urandom_range(0, 3) == 0); exmem_result = $urandom;
        memwb_wsel = 5'($urandom_range(0, 7)); memwb_wen = 1'($urandom); memwb_wdat = $urandom;
        flush = ($urandom_range(0, 15) == 0);
        ex_hold = allow_hold && ($urandom_range(0, 5) == 0);
    endtask

    // Monitor: one sample per cycle, just before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #4;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(e.valid));
                chk("ex_wen", 32'(ex_wen), 32'(e.wen));
                chk("ex_memread", 32'(ex_memread), 32'(e.memread));
                chk("stall_id", 32'(stall_id), 32'(e.stall));
                if (e.valid || e.in_rst) begin
                    chk("ex_wsel", 32'(ex_wsel), 32'(e.wsel));
                    chk("ex_rs", 32'(ex_rs), 32'(e.rs));
                    chk("ex_rt", 32'(ex_rt), 32'(e.rt));
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
                    chk("ex_opA", ex_opA, e.opa);
                    chk("ex_opB", ex_opB, e.opb);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        m = '0;
        quiet();
        RST = 1;
        @(negedge CLK);
        // Reset with random traffic on every input except the hold.
        for (int i = 0; i < 4; i++) begin
            randomize_inputs(1'b0);
            RST = 1;
            step();
        end
        quiet();
        step();

        // EX/MEM forward into operand A.
        decode(5'd3, 5'd7, 5'd9, 1'b0, 32'h1, 32'h2); step();
        quiet(); exmem_wen = 1; exmem_wsel = 3; exmem_result = 32'h0000_00AA; step();

        // EX/MEM beats MEM/WB; $0 never forwards.
        quiet(); decode(5'd1, 5'd5, 5'd9, 1'b0, 32'h3, 32'h77); step();
        quiet(); exmem_wen = 1; exmem_wsel = 5; exmem_result = 32'h11;
        memwb_wen = 1; memwb_wsel = 5; memwb_wdat = 32'h22; step();
        quiet(); decode(5'd0, 5'd0, 5'd9, 1'b0, 32'h98, 32'h99); step();
        quiet(); exmem_wen = 1; exmem_wsel = 0; exmem_result = 32'h11;
        memwb_wen = 1; memwb_wsel = 0; memwb_wdat = 32'h22; step();

        // Load-use: lw $4 then add using $4, one bubble, then MEM/WB forward.
        quiet(); decode(5'd1, 5'd2, 5'd4, 1'b1, 32'h5, 32'h6); step();
        quiet(); decode(5'd4, 5'd2, 5'd8, 1'b0, 32'h0, 32'h6); step();
        step();
        quiet(); memwb_wen = 1; memwb_wsel = 4; memwb_wdat = 32'hDEAD_BEEF; step();

        // Forwarded value retained through a 3-cycle hold.
        quiet(); decode(5'd6, 5'd1, 5'd2, 1'b0, 32'h1, 32'h2); step();
        quiet(); exmem_wen = 1; exmem_wsel = 6; exmem_result = 32'h55; ex_hold = 1; step();
        exmem_wen = 0; exmem_result = 32'h0; step();
        step();
        ex_hold = 0; step();

        // Flush wins over hold.
        quiet(); decode(5'd1, 5'd2, 5'd3, 1'b0, 32'h1, 32'h2); step();
        quiet(); flush = 1; ex_hold = 1; step();
        quiet(); step();

        // Reset arriving in the middle of a load-use stall.
        quiet(); decode(5'd1, 5'd2, 5'd2, 1'b1, 32'h1, 32'h2); step();
        quiet(); decode(5'd2, 5'd3, 5'd5, 1'b0, 32'h1, 32'h2); RST = 1; step();
        RST = 0; step();

        for (int i = 0; i < 2000; i++) begin
            randomize_inputs(1'b1);
            RST = ($urandom_range(0, 199) == 0);
            step();
        end

        #1;
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
